// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone master adapter: bus widths, the
// default bus-cycle timeout and the adapter FSM state encoding.
package wb_pkg;

  localparam int WB_ADDR_W          = 32;
  localparam int WB_DATA_W          = 32;
  localparam int WB_SEL_W           = 4;
  localparam int WB_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

  // Read data returned to the requester on a normal acknowledge:
  // the slave data for reads, zero for writes.
  function automatic logic [WB_DATA_W-1:0] ack_rdata(input logic we,
                                                     input logic [WB_DATA_W-1:0] dat);
    logic [WB_DATA_W-1:0] res;
    if (we) begin
      res = {WB_DATA_W{1'b0}};
    end else begin
      res = dat;
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_master_timer.sv
// Bus-cycle watchdog: counts cycles while run_i is high and flags the
// cycle in which the TIMEOUT_CYCLES-th consecutive cycle is reached.
// A TIMEOUT_CYCLES of 0 disables expiry altogether.
module wb_master_timer
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = WB_TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic run_i,
  output logic expired_o
);

  localparam logic [31:0] LIMIT   = 32'(TIMEOUT_CYCLES);
  localparam logic        ENABLED = (TIMEOUT_CYCLES != 0);

  logic [31:0] count_q;
  logic [31:0] count_d;
  logic        expired_s;

  // Expiry is flagged in the last allowed cycle so the owner terminates at that edge.
  always_comb begin
    expired_s = 1'b0;
    if (ENABLED && run_i && (count_q == (LIMIT - 32'd1))) begin
      expired_s = 1'b1;
    end else begin
      expired_s = 1'b0;
    end
  end

  // Next count: clear dominates, otherwise advance while running and not yet expired.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = 32'd0;
    end else if (ENABLED && run_i && !expired_s) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = expired_s;

endmodule

// File: rtl/wishbone_master_adapter.sv
// Converts a valid/ready request + response handshake into single
// Wishbone classic transfers. One transfer is in flight at a time:
// IDLE accepts a request, BUS holds the Wishbone cycle until ack, err or
// timeout, RESP presents the result until the requester takes it.
module wishbone_master_adapter
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = WB_TIMEOUT_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [WB_ADDR_W-1:0] req_addr_i,
  input  logic [WB_DATA_W-1:0] req_wdata_i,
  input  logic [WB_SEL_W-1:0]  req_sel_i,
  input  logic                 req_we_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [WB_DATA_W-1:0] rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic [WB_ADDR_W-1:0] wb_adr_o,
  output logic [WB_DATA_W-1:0] wb_dat_o,
  output logic [WB_SEL_W-1:0]  wb_sel_o,
  output logic                 wb_we_o,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  input  logic [WB_DATA_W-1:0] wb_dat_i,
  input  logic                 wb_ack_i,
  input  logic                 wb_err_i
);

  wb_state_e            state_q, state_d;
  logic [WB_ADDR_W-1:0] adr_q, adr_d;
  logic [WB_DATA_W-1:0] dat_q, dat_d;
  logic [WB_SEL_W-1:0]  sel_q, sel_d;
  logic                 we_q, we_d;
  logic                 cyc_q, cyc_d;
  logic                 ready_q, ready_d;
  logic                 rvalid_q, rvalid_d;
  logic [WB_DATA_W-1:0] rdata_q, rdata_d;
  logic                 rerr_q, rerr_d;
  logic                 timer_clear_s;
  logic                 timer_run_s;
  logic                 timer_expired_s;

  assign timer_run_s   = (state_q == ST_BUS);
  assign timer_clear_s = (state_q != ST_BUS);

  wb_master_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (timer_clear_s),
    .run_i    (timer_run_s),
    .expired_o(timer_expired_s)
  );

  // Next-state and next-output logic; slave inputs are only looked at in BUS.
  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    we_d     = we_q;
    cyc_d    = cyc_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && ready_q) begin
          adr_d   = req_addr_i;
          dat_d   = req_wdata_i;
          sel_d   = req_sel_i;
          we_d    = req_we_i;
          cyc_d   = 1'b1;
          state_d = ST_BUS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUS: begin
        // err outranks ack, and either outranks the timeout
        if (wb_err_i) begin
          rdata_d  = {WB_DATA_W{1'b0}};
          rerr_d   = 1'b1;
          cyc_d    = 1'b0;
          rvalid_d = 1'b1;
          state_d  = ST_RESP;
        end else if (wb_ack_i) begin
          rdata_d  = ack_rdata(we_q, wb_dat_i);
          rerr_d   = 1'b0;
          cyc_d    = 1'b0;
          rvalid_d = 1'b1;
          state_d  = ST_RESP;
        end else if (timer_expired_s) begin
          rdata_d  = {WB_DATA_W{1'b0}};
          rerr_d   = 1'b1;
          cyc_d    = 1'b0;
          rvalid_d = 1'b1;
          state_d  = ST_RESP;
        end else begin
          state_d = ST_BUS;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          rvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        cyc_d    = 1'b0;
        rvalid_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
    // ready is registered, so it reflects the state being entered
    if (state_d == ST_IDLE) begin
      ready_d = 1'b1;
    end else begin
      ready_d = 1'b0;
    end
  end

  // State and output registers; reset drops any transfer in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      adr_q    <= {WB_ADDR_W{1'b0}};
      dat_q    <= {WB_DATA_W{1'b0}};
      sel_q    <= {WB_SEL_W{1'b0}};
      we_q     <= 1'b0;
      cyc_q    <= 1'b0;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= {WB_DATA_W{1'b0}};
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      cyc_q    <= cyc_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rvalid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = rerr_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;
  assign wb_we_o     = we_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;

endmodule

// File: doc/wishbone_master_adapter.md
WISHBONE_MASTER_ADAPTER -- requirements
Module: wishbone_master_adapter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning bus-cycle cycles allowed without wb_ack_i/wb_err_i; 0 disables the timeout.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all logic on rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have req_valid_i in 1, req_ready_o out 1: core-side request handshake.
REQ-005 SHALL have req_addr_i in 32, req_wdata_i in 32, req_sel_i in 4, req_we_i in 1: request byte address, write data, byte enables, write flag.
REQ-006 SHALL have rsp_valid_o out 1, rsp_ready_i in 1, rsp_rdata_o out 32, rsp_err_o out 1: response handshake, read data, error flag.
REQ-007 SHALL have Wishbone master outputs wb_adr_o 32, wb_dat_o 32, wb_sel_o 4, wb_we_o 1, wb_cyc_o 1, wb_stb_o 1.
REQ-008 SHALL have Wishbone master inputs wb_dat_i 32, wb_ack_i 1, wb_err_i 1.

Function
REQ-009 SHALL implement FSM states IDLE, BUS, RESP; req_ready_o=1 only in IDLE after the first post-reset cycle.
REQ-010 SHALL, in IDLE when req_valid_i&&req_ready_o, register addr/wdata/sel/we onto wb_* outputs and enter BUS; wb_cyc_o=wb_stb_o=1 from the next cycle.
REQ-011 SHALL hold wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o stable throughout BUS (Wishbone classic, single transfer, no bursts).
REQ-012 SHALL, on wb_ack_i in BUS, capture wb_dat_i (reads) or 0 (writes) into rsp_rdata_o, set rsp_err_o=0, deassert wb_cyc_o/wb_stb_o at that edge, and enter RESP.
REQ-013 SHALL, on wb_err_i in BUS, set rsp_rdata_o=0, rsp_err_o=1, deassert cyc/stb, enter RESP; wb_err_i wins if asserted with wb_ack_i.
REQ-014 SHALL count cycles in BUS; when count reaches TIMEOUT_CYCLES with neither ack nor err, terminate as error (rsp_err_o=1, rdata 0); ack/err in the same cycle takes priority over timeout.
REQ-015 SHALL assert rsp_valid_o for the whole of RESP, holding rsp_rdata_o/rsp_err_o stable, and return to IDLE on the cycle rsp_valid_o&&rsp_ready_i.
REQ-016 SHALL ignore wb_ack_i, wb_err_i and wb_dat_i outside BUS.
REQ-017 SHALL give minimum latency: accept at edge N, cyc/stb high in N+1, zero-wait ack at N+1 gives rsp_valid_o in N+2, next acceptance possible at N+3 if rsp_ready_i=1 in N+2.
REQ-018 SHALL pass req_addr_i and req_sel_i unmodified; alignment and sel encoding are the requester's responsibility.

Reset
REQ-019 SHALL, on rst_i high, immediately force state IDLE, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=wb_dat_o=0, wb_sel_o=0, req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, timeout counter 0.
REQ-020 SHALL, on reset mid-transaction, abandon the cycle without producing a response; a later ack is ignored.
REQ-021 SHALL raise req_ready_o on the first clock edge after rst_i deasserts.

Structure
REQ-022 SHALL take FSM state encoding, WB_ADDR_W=32, WB_DATA_W=32, WB_SEL_W=4 and the TIMEOUT default from a shared package wb_pkg.
REQ-023 SHALL place the timeout counter in one sub-module wb_master_timer (inputs clear, run; output expired).

Verification
REQ-024 Read: req addr 0x0000_0010, we=0, sel=4'hF; slave acks after 2 waits with 0xDEAD_BEEF -> cyc/stb high 3 cycles, rsp_rdata_o=0xDEAD_BEEF, rsp_err_o=0.
REQ-025 Write: addr 0x0000_0020, wdata 0x1234_5678, sel=4'b0011, zero-wait ack -> wb_dat_o/wb_sel_o as given during cycle, rsp_valid_o at N+2, rsp_rdata_o=0.
REQ-026 Timeout: TIMEOUT_CYCLES=4, slave silent -> cyc/stb drop after 4 BUS cycles, rsp_err_o=1, rdata 0; ack arriving later ignored.
REQ-027 Backpressure/priority: rsp_ready_i low 3 cycles -> rsp_valid_o and data held, req_ready_o=0; ack+err same cycle -> rsp_err_o=1.
REQ-028 Reset mid-BUS: rst_i pulsed while cyc=1 -> cyc/stb=0 asynchronously, no rsp_valid_o, req_ready_o=1 one edge after release.
